// File: rtl/booth2_divider_pkg.sv
// Shared definitions for the signed divider that follows the Booth radix-4 multiplier.
package booth2_div_pkg;

  localparam int BIT_WIDTH = 16;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(BIT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/booth2_divider_div_step.sv
// One restoring-division iteration on magnitudes: shift in a dividend bit,
// trial-subtract the divisor, keep the difference only when it is non-negative.
module div_step
  import booth2_div_pkg::*;
#(
  parameter int W = BIT_WIDTH
) (
  input  logic [W:0]   i_prem,
  input  logic         i_bit,
  input  logic [W-1:0] i_dsr,
  output logic [W:0]   o_prem,
  output logic         o_qbit
);

  logic [W+1:0] w_shift;
  logic [W:0]   w_diff;
  logic         w_ge;

  assign w_shift = {i_prem, i_bit};
  assign w_ge    = (w_shift >= {2'b00, i_dsr});
  assign w_diff  = w_shift[W:0] - {1'b0, i_dsr};
  assign o_prem  = w_ge ? w_diff : w_shift[W:0];
  assign o_qbit  = w_ge;

endmodule

// File: rtl/booth2_divider.sv
// Sequential signed divider: 2W-bit dividend / W-bit divisor, one quotient bit per
// cycle on magnitudes, signs and range fixed up afterwards. Valid/ready on both sides.
module booth2_divider
  import booth2_div_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [2*bit_width-1:0] i_dividend,
  input  logic [bit_width-1:0]   i_divisor,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [bit_width-1:0]   o_quotient,
  output logic [bit_width-1:0]   o_remainder,
  output logic                   o_div_by_zero,
  output logic                   o_overflow
);

  localparam int W  = bit_width;
  localparam int DW = 2 * bit_width;
  localparam int CW = (bit_width == BIT_WIDTH) ? CNT_W : cnt_width(bit_width);
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [W-1:0]  NEG_LIM   = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  POS_LIM   = {1'b0, {(W-1){1'b1}}};

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [W:0]    r_prem;
  logic [W-1:0]  r_shift;
  logic [W-1:0]  r_dsr_mag;
  logic          r_neg_dvd;
  logic          r_neg_dsr;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_rem;
  logic          r_dbz;
  logic          r_ovf;

  logic [DW-1:0] w_dvd_mag;
  logic [W-1:0]  w_dsr_mag;
  logic          w_accept;
  logic          w_dsr_zero;
  logic          w_hi_ovf;
  logic [W:0]    w_prem_next;
  logic          w_qbit;
  logic          w_q_neg;
  logic [W-1:0]  w_q_signed;
  logic [W-1:0]  w_r_signed;
  logic          w_range_bad;

  // |-2^(2W-1)| wraps to itself, which is the correct unsigned magnitude
  assign w_dvd_mag  = i_dividend[DW-1] ? ({DW{1'b0}} - i_dividend) : i_dividend;
  assign w_dsr_mag  = i_divisor[W-1] ? ({W{1'b0}} - i_divisor) : i_divisor;
  assign w_accept   = i_in_valid & r_in_ready;
  assign w_dsr_zero = (i_divisor == {W{1'b0}});
  assign w_hi_ovf   = (w_dvd_mag[DW-1:W] >= w_dsr_mag);

  div_step #(.W(W)) u_div_step (
    .i_prem (r_prem),
    .i_bit  (r_shift[W-1]),
    .i_dsr  (r_dsr_mag),
    .o_prem (w_prem_next),
    .o_qbit (w_qbit)
  );

  assign w_q_neg     = r_neg_dvd ^ r_neg_dsr;
  assign w_q_signed  = w_q_neg ? ({W{1'b0}} - r_shift) : r_shift;
  assign w_r_signed  = r_neg_dvd ? ({W{1'b0}} - r_prem[W-1:0]) : r_prem[W-1:0];
  // A set top remainder bit cannot occur; treating it as overflow keeps bad data out
  assign w_range_bad = r_prem[W] | (w_q_neg ? (r_shift > NEG_LIM) : (r_shift > POS_LIM));

  // Control FSM, iteration datapath and registered result
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= {CW{1'b0}};
      r_prem      <= {(W+1){1'b0}};
      r_shift     <= {W{1'b0}};
      r_dsr_mag   <= {W{1'b0}};
      r_neg_dvd   <= 1'b0;
      r_neg_dsr   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= {W{1'b0}};
      r_rem       <= {W{1'b0}};
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_neg_dvd  <= i_dividend[DW-1];
            r_neg_dsr  <= i_divisor[W-1];
            r_prem     <= {1'b0, w_dvd_mag[DW-1:W]};
            r_shift    <= w_dvd_mag[W-1:0];
            r_dsr_mag  <= w_dsr_mag;
            r_cnt      <= {CW{1'b0}};
            r_in_ready <= 1'b0;
            r_quot     <= {W{1'b0}};
            r_rem      <= {W{1'b0}};
            if (w_dsr_zero) begin
              r_dbz   <= 1'b1;
              r_ovf   <= 1'b0;
              r_state <= DONE;
            end else if (w_hi_ovf) begin
              r_dbz   <= 1'b0;
              r_ovf   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dbz   <= 1'b0;
              r_ovf   <= 1'b0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_prem  <= w_prem_next;
          r_shift <= {r_shift[W-2:0], w_qbit};
          r_cnt   <= r_cnt + CNT_ONE;
          if (r_cnt == LAST_ITER) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          if (w_range_bad) begin
            r_ovf  <= 1'b1;
            r_quot <= {W{1'b0}};
            r_rem  <= {W{1'b0}};
          end else begin
            r_quot <= w_q_signed;
            r_rem  <= w_r_signed;
          end
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          // The error short-cut arrives here with valid still low; raise it one edge later
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_out_valid   = r_out_valid;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_rem;
  assign o_div_by_zero = r_dbz;
  assign o_overflow    = r_ovf;

endmodule
